// File: rtl/majority_window_voter_if.sv
// Bundle between a sample source and majority_window_voter.
// The source drives samples and config; the voter returns both results.
interface majority_window_voter_if #(
  parameter int N = 5,
  parameter int W = 7
);
  localparam int CW = $clog2(N + 1);
  localparam int WW = $clog2(W + 1);

  logic          flush;
  logic          in_valid;
  logic [N-1:0]  in_bits;
  logic [CW-1:0] thresh;
  logic          vote_valid;
  logic          vote_now;
  logic [CW-1:0] vote_count;
  logic          disagree;
  logic          out_valid;
  logic          out;
  logic [WW-1:0] win_count;
  logic          win_full;

  modport master (
    output flush, in_valid, in_bits, thresh,
    input  vote_valid, vote_now, vote_count, disagree,
    input  out_valid, out, win_count, win_full
  );

  modport slave (
    input  flush, in_valid, in_bits, thresh,
    output vote_valid, vote_now, vote_count, disagree,
    output out_valid, out, win_count, win_full
  );
endinterface

// File: rtl/majority_window_voter.sv
// N-channel spatial majority vote followed by a W-deep
// sliding-window temporal majority filter.
module majority_window_voter #(
  parameter int N = 5,
  parameter int W = 7
) (
  input logic clk,
  input logic rst,
  majority_window_voter_if.slave bus
);
  localparam int CW = $clog2(N + 1);
  localparam int WW = $clog2(W + 1);
  localparam logic [CW-1:0] DEF_T = CW'(N / 2 + 1);
  localparam logic [WW-1:0] WMAX = WW'(W);
  localparam logic [WW:0] WCMP = (WW + 1)'(W);

  logic          vote_valid_q, vote_now_q, disagree_q;
  logic [CW-1:0] vote_count_q;
  logic          out_valid_q, out_q, win_full_q;
  logic [WW-1:0] win_count_q, fill_q;
  logic [W-1:0]  win_q;

  logic [CW-1:0] pop, thr;
  logic          vote_n, dis_n;
  logic [W:0]    shifted;
  logic [W-1:0]  win_n;
  logic [WW-1:0] cnt_n, fill_n;
  logic          full_n;

  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++) begin
      pop = pop + CW'(bus.in_bits[i]);
    end
    thr    = (bus.thresh == '0) ? DEF_T : bus.thresh;
    vote_n = (pop >= thr);
    dis_n  = |(bus.in_bits ^ {N{vote_n}});
  end

  // Window update; the oldest sample only leaves once the window is full.
  always_comb begin
    shifted = {win_q, vote_now_q};
    win_n   = shifted[W-1:0];
    cnt_n   = win_count_q;
    fill_n  = fill_q;
    if (fill_q < WMAX) begin
      cnt_n  = win_count_q + WW'(vote_now_q);
      fill_n = fill_q + WW'(1);
    end else begin
      cnt_n = win_count_q + WW'(vote_now_q) - WW'(win_q[W-1]);
    end
    full_n = (fill_n == WMAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vote_valid_q <= 1'b0;
      vote_now_q   <= 1'b0;
      vote_count_q <= '0;
      disagree_q   <= 1'b0;
    end else if (bus.flush) begin
      vote_valid_q <= 1'b0;
    end else begin
      vote_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        vote_now_q   <= vote_n;
        vote_count_q <= pop;
        disagree_q   <= dis_n;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_q       <= '0;
      fill_q      <= '0;
      win_count_q <= '0;
      win_full_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= 1'b0;
    end else if (bus.flush) begin
      win_q       <= '0;
      fill_q      <= '0;
      win_count_q <= '0;
      win_full_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (vote_valid_q) begin
      win_q       <= win_n;
      fill_q      <= fill_n;
      win_count_q <= cnt_n;
      win_full_q  <= full_n;
      out_valid_q <= full_n;
      if (full_n) begin
        out_q <= ({cnt_n, 1'b0} > WCMP);
      end
    end else begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.vote_valid = vote_valid_q;
  assign bus.vote_now   = vote_now_q;
  assign bus.vote_count = vote_count_q;
  assign bus.disagree   = disagree_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out        = out_q;
  assign bus.win_count  = win_count_q;
  assign bus.win_full   = win_full_q;
endmodule

// File: tb/tb_majority_window_voter.sv
// Directed and random bench for majority_window_voter against
// a queue-based reference of the vote and window rules.
module tb_majority_window_voter;
  localparam int N = 5;
  localparam int W = 7;

  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int bad = 0;

  majority_window_voter_if #(.N(N), .W(W)) bus ();

  majority_window_voter #(.N(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // reference state
  bit m_vv, m_vn, m_dis, m_ov, m_out;
  int m_vc;
  bit q[$];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int qsum();
    int s = 0;
    foreach (q[i]) s += q[i];
    return s;
  endfunction

  task automatic model(bit r, bit fl, bit v, logic [N-1:0] b, int th);
    int t;
    if (r) begin
      m_vv = 0; m_vn = 0; m_vc = 0; m_dis = 0;
      m_ov = 0; m_out = 0; q.delete();
      return;
    end
    if (fl) begin
      q.delete(); m_vv = 0; m_ov = 0;
      return;
    end
    m_ov = 0;
    if (m_vv) begin
      q.push_back(m_vn);
      if (q.size() > W) void'(q.pop_front());
      if (q.size() == W) begin
        m_ov = 1;
        m_out = (2 * qsum() > W);
      end
    end
    m_vv = v;
    if (v) begin
      m_vc = $countones(b);
      t = (th == 0) ? N / 2 + 1 : th;
      m_vn = (m_vc >= t);
      m_dis = m_vn ? (m_vc != N) : (m_vc != 0);
    end
  endtask

  task automatic step(bit r, bit fl, bit v, logic [N-1:0] b, int th);
    rst = r;
    bus.flush = fl;
    bus.in_valid = v;
    bus.in_bits = b;
    bus.thresh = 3'(th);
    @(posedge clk);
    #1;
    model(r, fl, v, b, th);
    chk("vote_valid", 32'(bus.vote_valid), 32'(m_vv));
    chk("vote_now", 32'(bus.vote_now), 32'(m_vn));
    chk("vote_count", 32'(bus.vote_count), 32'(m_vc));
    chk("disagree", 32'(bus.disagree), 32'(m_dis));
    chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
    chk("out", 32'(bus.out), 32'(m_out));
    chk("win_count", 32'(bus.win_count), 32'(qsum()));
    chk("win_full", 32'(bus.win_full), 32'(q.size() == W));
  endtask

  task automatic vote(bit one, int gap);
    step(0, 0, 1, one ? 5'b11111 : 5'b00000, 0);
    for (int g = 0; g < gap; g++) step(0, 0, 0, 5'b01010, 0);
  endtask

  initial begin
    bit stream[8] = '{1, 1, 0, 1, 0, 0, 1, 0};
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_bits = '0;
    bus.thresh = '0;

    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
    chk("rst_out", 32'(bus.out), 32'd0);
    chk("rst_wc", 32'(bus.win_count), 32'd0);

    // spatial vote, default and explicit thresholds
    step(0, 0, 1, 5'b10110, 0);
    chk("v10110", {bus.vote_now, bus.disagree, 27'd0, bus.vote_count},
        {1'b1, 1'b1, 27'd0, 3'd3});
    step(0, 0, 1, 5'b00011, 0);
    step(0, 0, 1, 5'b11111, 0);
    step(0, 0, 1, 5'b11110, 5);
    chk("th5", 32'(bus.vote_now), 32'd0);
    step(0, 0, 1, 5'b11111, 6);
    chk("th6", 32'(bus.vote_now), 32'd0);
    step(0, 0, 1, 5'b00001, 1);
    chk("th1", 32'(bus.vote_now), 32'd1);

    // fresh window, back-to-back stream
    step(1, 0, 0, 0, 0);
    foreach (stream[i]) vote(stream[i], 0);
    step(0, 0, 0, 0, 0);
    chk("w8_count", 32'(bus.win_count), 32'd3);
    chk("w8_out", 32'(bus.out), 32'd0);

    // same stream with bubbles
    step(1, 0, 0, 0, 0);
    foreach (stream[i]) vote(stream[i], 1 + (i % 3));

    // flush together with a sample after 4 samples
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) vote(stream[i], 0);
    step(0, 1, 1, 5'b11111, 0);
    step(0, 0, 0, 0, 0);
    chk("flush_wc", 32'(bus.win_count), 32'd0);
    for (int i = 0; i < 7; i++) vote(1'b1, 0);
    step(0, 0, 0, 0, 0);

    // reset mid-stream
    for (int i = 0; i < 3; i++) vote(1'b0, 0);
    step(1, 0, 1, 5'b11111, 0);
    chk("rst_vn", 32'(bus.vote_now), 32'd0);

    for (int i = 0; i < 400; i++) begin
      bit r = ($urandom_range(0, 99) < 2);
      bit f = ($urandom_range(0, 99) < 3);
      bit v = ($urandom_range(0, 99) < 70);
      step(r, f, v, 5'($urandom), $urandom_range(0, 7));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
